// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode 7-segment driver fed with packed BCD.
// New values wait in a one-deep pending slot and are only copied into the
// display register at the end of a full scan, so a frame never mixes values.

// One digit: segment pattern (active-high {g..a}), zero and invalid flags.
module bcd_seg_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg_on,
  output logic       zero,
  output logic       bad
);
  // Digit decode; A-F show a dash.
  always_comb begin
    seg_on = 7'h40;
    case (nib)
      4'd0: seg_on = 7'h3F;
      4'd1: seg_on = 7'h06;
      4'd2: seg_on = 7'h5B;
      4'd3: seg_on = 7'h4F;
      4'd4: seg_on = 7'h66;
      4'd5: seg_on = 7'h6D;
      4'd6: seg_on = 7'h7D;
      4'd7: seg_on = 7'h07;
      4'd8: seg_on = 7'h7F;
      4'd9: seg_on = 7'h6F;
      default: seg_on = 7'h40;
    endcase
  end

  assign zero = (nib == 4'd0);
  assign bad  = (nib > 4'd9);
endmodule

module bcd_seg_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    err_digit
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]                   cnt;
  logic [IW-1:0]                   idx;
  logic                            tick, last, boundary, accept;
  logic                            pend_full;
  logic [4*NUM_DIGITS-1:0]         pend_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0]           pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0][6:0]      lane_seg;
  logic [NUM_DIGITS-1:0]           lane_zero, lane_bad, upper_zero;
  logic                            run_zero, blank;

  assign load_ready = !pend_full;
  assign accept     = load_valid && load_ready;
  assign tick       = (cnt == CW'(REFRESH_DIV - 1));
  assign last       = (idx == IW'(NUM_DIGITS - 1));
  assign boundary   = tick && last;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    bcd_seg_lane u_lane (
      .nib    (disp_bcd[4*g +: 4]),
      .seg_on (lane_seg[g]),
      .zero   (lane_zero[g]),
      .bad    (lane_bad[g])
    );
  end

  // upper_zero[i]: digits i..top of the display register are all zero.
  always_comb begin
    upper_zero = '0;
    run_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & lane_zero[i];
      upper_zero[i] = run_zero;
    end
  end

  assign blank = (BLANK_LZ != 0) && (idx != '0) && upper_zero[idx];

  // Refresh divider and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending slot fills on accept and drains into the display at a frame boundary.
  // The two cases are exclusive: accept needs an empty slot, the copy a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      disp_bcd  <= '0;
      disp_dp   <= '0;
    end else begin
      if (boundary && pend_full) begin
        disp_bcd  <= pend_bcd;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end
      if (accept) begin
        pend_bcd  <= bcd_in;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end
    end
  end

  // Registered display outputs, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_out    <= '1;
      seg_out   <= 7'h7F;
      dp_out    <= 1'b1;
      err_digit <= 1'b0;
    end else begin
      err_digit <= |lane_bad;
      if (blank) begin
        an_out  <= '1;
        seg_out <= 7'h7F;
        dp_out  <= 1'b1;
      end else begin
        an_out  <= ~(NUM_DIGITS'(1) << idx);
        seg_out <= ~lane_seg[idx];
        dp_out  <= ~disp_dp[idx];
      end
    end
  end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: scenario tasks plus a frame-level reference model.
module tb_bcd_seg_scan;
  localparam int N     = 8;
  localparam int RD    = 4;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bcd_in = '0;
  logic [7:0]  dp_in = '0;
  logic        load_valid = 1'b0;

  logic        load_ready, dp_out, err_digit;
  logic [7:0]  an_out;
  logic [6:0]  seg_out;
  logic        load_ready2, dp_out2, err_digit2;
  logic [7:0]  an_out2;
  logic [6:0]  seg_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load_valid(load_valid),
    .load_ready(load_ready), .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
    .err_digit(err_digit)
  );

  bcd_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load_valid(load_valid),
    .load_ready(load_ready2), .an_out(an_out2), .seg_out(seg_out2), .dp_out(dp_out2),
    .err_digit(err_digit2)
  );

  // ---------------- reference model ----------------
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int          m_t;      // position within the frame, 0..FRAME-1
  logic        m_pfull;
  logic [31:0] m_pend, m_disp;
  logic [7:0]  m_pdp, m_dpd;
  logic [7:0]  e_an, e2_an;
  logic [6:0]  e_seg, e2_seg;
  logic        e_dp, e2_dp, e_err;

  function automatic logic [15:0] model_out(input logic [31:0] v, input logic [7:0] dpv,
                                            input int d, input bit lz);
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * d);
    nib   = upper[3:0];
    if (lz && d > 0 && upper == 32'd0) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'd1 << d), ~dec_tab[nib], ~dpv[d]};
  endfunction

  function automatic logic model_err(input logic [31:0] v);
    for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t     <= 0;
      m_pfull <= 1'b0;
      m_disp  <= '0;
      m_dpd   <= '0;
      {e_an, e_seg, e_dp}    <= {8'hFF, 7'h7F, 1'b1};
      {e2_an, e2_seg, e2_dp} <= {8'hFF, 7'h7F, 1'b1};
      e_err   <= 1'b0;
    end else begin
      {e_an, e_seg, e_dp}    <= model_out(m_disp, m_dpd, m_t / RD, 1'b1);
      {e2_an, e2_seg, e2_dp} <= model_out(m_disp, m_dpd, m_t / RD, 1'b0);
      e_err <= model_err(m_disp);
      if (m_t == FRAME - 1 && m_pfull) begin
        m_disp  <= m_pend;
        m_dpd   <= m_pdp;
        m_pfull <= 1'b0;
      end
      if (load_valid && !m_pfull) begin
        m_pend  <= bcd_in;
        m_pdp   <= dp_in;
        m_pfull <= 1'b1;
      end
      m_t <= (m_t + 1) % FRAME;
    end
  end

  wire [17:0] obs   = {an_out, seg_out, dp_out, err_digit, load_ready};
  wire [17:0] exp_v = {e_an, e_seg, e_dp, e_err, ~m_pfull};
  wire [17:0] obs2  = {an_out2, seg_out2, dp_out2, err_digit2, load_ready2};
  wire [17:0] exp2  = {e2_an, e2_seg, e2_dp, e_err, ~m_pfull};

  // Stimulus: wait for ready (bounded), present one value for one cycle.
  task automatic load(input logic [31:0] v, input logic [7:0] d);
    int n = 0;
    while (!load_ready && n < 3 * FRAME) begin @(negedge clk); n++; end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_wait: load_ready=%b, required 1", load_ready);
    end
    bcd_in = v; dp_in = d; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int low_hits = 0;
    rst = 1'b1; load_valid = 1'b1; bcd_in = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
        errors++; $display("FAIL reset_state: got %h required %h", obs, {8'hFF, 7'h7F, 3'b101});
      end
    end
    load_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== {8'hFE, 7'h40, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL first_output: got %h required %h", obs, {8'hFE, 7'h40, 3'b101});
    end
    repeat (2 * FRAME) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_scan: got %h required %h", obs, exp_v); end
      if (an_out[7:1] !== 7'h7F) low_hits++;
    end
    checks++;
    if (low_hits != 0) begin errors++; $display("FAIL reset_blank: upper anodes low %0d times, required 0", low_hits); end
  endtask

  task automatic test_load_1234();
    logic [6:0] seg_seen [8];
    logic       dp_seen [8];
    int         hi_low = 0;
    logic [7:0] m;
    for (int k = 0; k < 8; k++) begin seg_seen[k] = 7'h00; dp_seen[k] = 1'bx; end
    load(32'h0000_1234, 8'h04);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b required 0", load_ready); end
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL load_scan: got %h required %h", obs, exp_v); end
    end
    repeat (FRAME) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL load_frame: got %h required %h", obs, exp_v); end
      for (int k = 0; k < 8; k++) begin
        m = ~(8'd1 << k);
        if (an_out === m) begin seg_seen[k] = seg_out; dp_seen[k] = dp_out; end
      end
      if (an_out[7:4] !== 4'hF) hi_low++;
    end
    checks++;
    if (seg_seen[0] !== 7'h19 || seg_seen[1] !== 7'h30 || seg_seen[2] !== 7'h24 || seg_seen[3] !== 7'h79) begin
      errors++;
      $display("FAIL digits_1234: got %h %h %h %h required 19 30 24 79",
               seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]);
    end
    checks++;
    if (dp_seen[2] !== 1'b0 || dp_seen[0] !== 1'b1) begin
      errors++; $display("FAIL dp_1234: dp2=%b dp0=%b required 0 1", dp_seen[2], dp_seen[0]);
    end
    checks++;
    if (hi_low != 0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL blank_1234: upper low %0d ready %b, required 0 1", hi_low, load_ready);
    end
  endtask

  task automatic test_backpressure();
    int  held = 0, t_a = -1, t_b = -1;
    bit  acc_next = 0, accepted = 0;
    load(32'h0000_0011, 8'h00);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b required 0", load_ready); end
    bcd_in = 32'h0000_0022; load_valid = 1'b1;
    for (int n = 0; n < 4 * FRAME + 8; n++) begin
      if (load_valid && load_ready) acc_next = 1;
      else if (load_valid) held++;
      @(negedge clk);
      if (acc_next) begin load_valid = 1'b0; acc_next = 0; accepted = 1; end
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_scan: got %h required %h", obs, exp_v); end
      if (an_out === 8'hFE && seg_out === 7'h79 && t_a < 0) t_a = n;
      if (an_out === 8'hFE && seg_out === 7'h24 && t_b < 0) t_b = n;
    end
    load_valid = 1'b0;
    checks++;
    if (!accepted || held == 0) begin
      errors++; $display("FAIL bp_hold: accepted=%0d held=%0d, required 1 and >0", accepted, held);
    end
    checks++;
    if (t_a < 0 || t_b - t_a != FRAME) begin
      errors++; $display("FAIL bp_frame: A at %0d B at %0d, required spacing %0d", t_a, t_b, FRAME);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] seg_seen [8];
    int         hi_low = 0;
    logic [7:0] m;
    for (int k = 0; k < 8; k++) seg_seen[k] = 7'h00;
    load(32'h0000_F000, 8'h00);
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL inv_scan: got %h required %h", obs, exp_v); end
    end
    repeat (FRAME) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        m = ~(8'd1 << k);
        if (an_out === m) seg_seen[k] = seg_out;
      end
      if (an_out[7:4] !== 4'hF) hi_low++;
    end
    checks++;
    if (seg_seen[3] !== 7'h3F || seg_seen[0] !== 7'h40 || seg_seen[1] !== 7'h40 || seg_seen[2] !== 7'h40) begin
      errors++;
      $display("FAIL inv_digits: got %h %h %h %h required 40 40 40 3F",
               seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]);
    end
    checks++;
    if (hi_low != 0 || err_digit !== 1'b1) begin
      errors++; $display("FAIL inv_err: upper low %0d err %b, required 0 1", hi_low, err_digit);
    end
    load(32'h0, 8'h00);
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL inv_clear_scan: got %h required %h", obs, exp_v); end
    end
    checks++;
    if (err_digit !== 1'b0) begin errors++; $display("FAIL inv_clear: err %b required 0", err_digit); end
  endtask

  task automatic test_boundary_accept();
    int found = -1, n = 0;
    while ((m_t != FRAME - 1 || !load_ready) && n < 4 * FRAME) begin @(negedge clk); n++; end
    checks++;
    if (m_t != FRAME - 1 || load_ready !== 1'b1) begin
      errors++; $display("FAIL bnd_align: t=%0d ready=%b required %0d 1", m_t, load_ready, FRAME - 1);
    end
    bcd_in = 32'h0000_0077; dp_in = 8'h00; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bnd_scan: got %h required %h", obs, exp_v); end
      if (an_out === 8'hFE && seg_out === 7'h78 && found < 0) found = i;
    end
    checks++;
    if (found != FRAME + 1) begin
      errors++; $display("FAIL bnd_latency: shown after %0d cycles, required %0d", found, FRAME + 1);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0, hi_low = 0, old_seen = 0, zero_bad = 0;
    while (m_t != 1 && n < 2 * FRAME) begin @(negedge clk); n++; end
    load(32'h0000_0099, 8'h01);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b required 1", load_ready); end
    repeat (3 * FRAME) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mr_scan: got %h required %h", obs, exp_v); end
      if (an_out[7:1] !== 7'h7F) hi_low++;
      if (seg_out === 7'h10) old_seen++;
      if (an_out === 8'hFE && seg_out !== 7'h40) zero_bad++;
    end
    checks++;
    if (hi_low != 0 || old_seen != 0 || zero_bad != 0) begin
      errors++;
      $display("FAIL mr_display: upper low %0d old %0d bad zero %0d, required 0 0 0", hi_low, old_seen, zero_bad);
    end
  endtask

  task automatic test_no_blank();
    logic [7:0] seen = 8'h00;
    logic [6:0] seg0 = 7'h00;
    int         bad = 0;
    load(32'h0000_0005, 8'h00);
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      checks++;
      if (obs2 !== exp2) begin errors++; $display("FAIL nolz_scan: got %h required %h", obs2, exp2); end
    end
    repeat (FRAME) begin
      @(negedge clk);
      seen = seen | ~an_out2;
      if (an_out2 === 8'hFE) seg0 = seg_out2;
      else if (an_out2 !== 8'hFF && seg_out2 !== 7'h40) bad++;
    end
    checks++;
    if (seen !== 8'hFF || bad != 0 || seg0 !== 7'h12) begin
      errors++; $display("FAIL nolz_digits: anodes %h bad %0d seg0 %h, required FF 0 12", seen, bad, seg0);
    end
  endtask

  task automatic test_random();
    bit          was_acc = 1;
    int          nd;
    logic [31:0] v;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rand_scan: got %h required %h", obs, exp_v); end
      checks++;
      if (obs2 !== exp2) begin errors++; $display("FAIL rand_nolz: got %h required %h", obs2, exp2); end
      if (!load_valid || was_acc) begin
        nd = $urandom_range(0, 8);
        v  = '0;
        for (int i = 0; i < 8; i++) if (i < nd) v[4*i +: 4] = 4'($urandom_range(0, 11));
        bcd_in     = v;
        dp_in      = 8'($urandom);
        load_valid = ($urandom_range(0, 3) == 0);
      end
      was_acc = load_valid && load_ready;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_backpressure();
    test_invalid();
    test_boundary_accept();
    test_mid_reset();
    test_no_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
